// File: rtl/mips_pipeline_pkg.sv
// ---------------------------------------------------------------------------
// mips_pipeline_pkg
// Shared types for the MIPS five-stage pipeline hazard logic.
//   state_t     : hazard scoreboard states (RUN, LOAD_WAIT, MEM_WAIT)
//   fwd_sel_t   : Execute-stage operand source select
//   BUBBLE_COUNTER_WIDTH : width of the load-use bubble counter
// ---------------------------------------------------------------------------
package mips_pipeline_pkg;

    localparam int BUBBLE_COUNTER_WIDTH = 3;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LOAD_WAIT = 2'd1,
        MEM_WAIT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FWD_REGFILE   = 2'b00,
        FWD_MEMORY    = 2'b01,
        FWD_WRITEBACK = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/mips_hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// mips_hazard_scoreboard_if
// Bundle of every pipeline-side signal seen by the hazard scoreboard.
//   master : the pipeline (drives stage addresses/enables, receives controls)
//   slave  : the scoreboard (receives stage info, drives enables/flushes,
//            forwarding selects and performance counters)
// ---------------------------------------------------------------------------
interface mips_hazard_scoreboard_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int COUNT_WIDTH    = 32
);
    // Decode stage
    logic [REG_ADDR_WIDTH-1:0] addressReadA_Decode;
    logic [REG_ADDR_WIDTH-1:0] addressReadB_Decode;
    logic                      useReadA_Decode;
    logic                      useReadB_Decode;
    logic                      enableJumpProgramCounter_Decode;
    // Execute stage
    logic [REG_ADDR_WIDTH-1:0] addressReadA_Execute;
    logic [REG_ADDR_WIDTH-1:0] addressReadB_Execute;
    logic                      enableReadDataMemory_Execute;
    logic [REG_ADDR_WIDTH-1:0] addressWriteRegisterFile_Execute;
    logic                      enableBranchProgramCounter_Execute;
    // MemoryAccess stage
    logic                      enableWriteRegisterFile_MemoryAccess;
    logic                      enableReadDataMemory_MemoryAccess;
    logic [REG_ADDR_WIDTH-1:0] addressWriteRegisterFile_MemoryAccess;
    logic                      dataMemoryRequest_MemoryAccess;
    logic                      dataMemoryReady;
    // WriteBack stage
    logic                      enableWriteRegisterFile_WriteBack;
    logic [REG_ADDR_WIDTH-1:0] addressWriteRegisterFile_WriteBack;
    // Controls back to the pipeline
    logic                      enableProgramCounter_HazardUnit;
    logic                      enableFetch_HazardUnit;
    logic                      enableDecode_HazardUnit;
    logic                      enableExecute_HazardUnit;
    logic                      enableMemoryAccess_HazardUnit;
    logic                      controlSignalSendNoOperation_HazardUnit;
    logic                      flushFetch_HazardUnit;
    logic                      flushDecode_HazardUnit;
    logic [1:0]                forwardA_HazardUnit;
    logic [1:0]                forwardB_HazardUnit;
    logic [COUNT_WIDTH-1:0]    stallCycleCount;
    logic [COUNT_WIDTH-1:0]    flushCount;

    modport master (
        output addressReadA_Decode, addressReadB_Decode, useReadA_Decode, useReadB_Decode,
               enableJumpProgramCounter_Decode,
               addressReadA_Execute, addressReadB_Execute, enableReadDataMemory_Execute,
               addressWriteRegisterFile_Execute, enableBranchProgramCounter_Execute,
               enableWriteRegisterFile_MemoryAccess, enableReadDataMemory_MemoryAccess,
               addressWriteRegisterFile_MemoryAccess, dataMemoryRequest_MemoryAccess,
               dataMemoryReady,
               enableWriteRegisterFile_WriteBack, addressWriteRegisterFile_WriteBack,
        input  enableProgramCounter_HazardUnit, enableFetch_HazardUnit, enableDecode_HazardUnit,
               enableExecute_HazardUnit, enableMemoryAccess_HazardUnit,
               controlSignalSendNoOperation_HazardUnit, flushFetch_HazardUnit,
               flushDecode_HazardUnit, forwardA_HazardUnit, forwardB_HazardUnit,
               stallCycleCount, flushCount
    );

    modport slave (
        input  addressReadA_Decode, addressReadB_Decode, useReadA_Decode, useReadB_Decode,
               enableJumpProgramCounter_Decode,
               addressReadA_Execute, addressReadB_Execute, enableReadDataMemory_Execute,
               addressWriteRegisterFile_Execute, enableBranchProgramCounter_Execute,
               enableWriteRegisterFile_MemoryAccess, enableReadDataMemory_MemoryAccess,
               addressWriteRegisterFile_MemoryAccess, dataMemoryRequest_MemoryAccess,
               dataMemoryReady,
               enableWriteRegisterFile_WriteBack, addressWriteRegisterFile_WriteBack,
        output enableProgramCounter_HazardUnit, enableFetch_HazardUnit, enableDecode_HazardUnit,
               enableExecute_HazardUnit, enableMemoryAccess_HazardUnit,
               controlSignalSendNoOperation_HazardUnit, flushFetch_HazardUnit,
               flushDecode_HazardUnit, forwardA_HazardUnit, forwardB_HazardUnit,
               stallCycleCount, flushCount
    );
endinterface

// File: rtl/mips_forward_select.sv
// ---------------------------------------------------------------------------
// mips_forward_select
// Chooses the source of one Execute-stage operand.
//   i_addressSource              : Execute source register
//   i_enableWrite/Read/Address*_MemoryAccess : MemoryAccess producer
//   i_enableWrite/Address*_WriteBack         : WriteBack producer
//   o_forwardSelect              : FWD_MEMORY / FWD_WRITEBACK / FWD_REGFILE
// ---------------------------------------------------------------------------
module mips_forward_select
    import mips_pipeline_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] i_addressSource,
    input  logic                      i_enableWrite_MemoryAccess,
    input  logic                      i_enableRead_MemoryAccess,
    input  logic [REG_ADDR_WIDTH-1:0] i_addressWrite_MemoryAccess,
    input  logic                      i_enableWrite_WriteBack,
    input  logic [REG_ADDR_WIDTH-1:0] i_addressWrite_WriteBack,
    output fwd_sel_t                  o_forwardSelect
);

    logic w_sourceNonZero;
    assign w_sourceNonZero = (i_addressSource != '0);

    // A load in MemoryAccess has no data yet (load-use stall covers it), so
    // only ALU results are forwarded from there. The younger producer wins.
    always_comb begin
        o_forwardSelect = FWD_REGFILE;
        if (i_enableWrite_MemoryAccess && !i_enableRead_MemoryAccess && w_sourceNonZero &&
            (i_addressWrite_MemoryAccess == i_addressSource)) begin
            o_forwardSelect = FWD_MEMORY;
        end else if (i_enableWrite_WriteBack && w_sourceNonZero &&
                     (i_addressWrite_WriteBack == i_addressSource)) begin
            o_forwardSelect = FWD_WRITEBACK;
        end
    end

endmodule

// File: rtl/mips_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// mips_hazard_scoreboard
// Hazard and forwarding controller for the five-stage MIPS pipeline:
// load-use bubbles, data-memory freeze, branch/jump flushes, operand
// forwarding selects and saturating stall/flush counters.
//   clock        : pipeline clock
//   resetMachine : synchronous active-high reset
//   bus          : mips_hazard_scoreboard_if.slave (all stage signals)
// ---------------------------------------------------------------------------
module mips_hazard_scoreboard
    import mips_pipeline_pkg::*;
#(
    parameter int REG_ADDR_WIDTH   = 5,
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int COUNT_WIDTH      = 32
) (
    input  logic                    clock,
    input  logic                    resetMachine,
    mips_hazard_scoreboard_if.slave bus
);

    localparam logic [BUBBLE_COUNTER_WIDTH-1:0] BUBBLE_INIT =
        BUBBLE_COUNTER_WIDTH'(LOAD_USE_BUBBLES - 1);
    localparam logic [BUBBLE_COUNTER_WIDTH-1:0] BUBBLE_ONE  = BUBBLE_COUNTER_WIDTH'(1);
    localparam bit                              MULTI_BUBBLE = (LOAD_USE_BUBBLES > 1);

    function automatic logic [COUNT_WIDTH-1:0] f_saturatingIncrement(
        input logic [COUNT_WIDTH-1:0] value
    );
        if (&value) return value;
        return value + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_t                          r_state;
    state_t                          r_resumeState;
    logic [BUBBLE_COUNTER_WIDTH-1:0] r_bubbleCounter;
    logic [COUNT_WIDTH-1:0]          r_stallCycleCount;
    logic [COUNT_WIDTH-1:0]          r_flushCount;

    state_t                          w_nextState;
    state_t                          w_nextResumeState;
    state_t                          w_effectiveState;
    logic [BUBBLE_COUNTER_WIDTH-1:0] w_nextBubbleCounter;
    logic                            w_freeze;
    logic                            w_loadUse;
    logic                            w_hitA;
    logic                            w_hitB;
    logic                            w_enableFront;
    logic                            w_enableBack;
    logic                            w_noOperation;
    logic                            w_flushFetch;
    logic                            w_flushDecode;
    fwd_sel_t                        w_forwardA;
    fwd_sel_t                        w_forwardB;

    assign w_freeze = bus.dataMemoryRequest_MemoryAccess && !bus.dataMemoryReady;

    // MEM_WAIT releases in the same cycle ready arrives, so once the freeze
    // drops the block already behaves as the state it was parked in.
    assign w_effectiveState = (r_state == MEM_WAIT) ? r_resumeState : r_state;

    assign w_hitA = bus.useReadA_Decode &&
                    (bus.addressReadA_Decode == bus.addressWriteRegisterFile_Execute);
    assign w_hitB = bus.useReadB_Decode &&
                    (bus.addressReadB_Decode == bus.addressWriteRegisterFile_Execute);
    assign w_loadUse = bus.enableReadDataMemory_Execute &&
                       (bus.addressWriteRegisterFile_Execute != '0) && (w_hitA || w_hitB);

    always_comb begin
        w_enableFront       = 1'b1;   // PC, Fetch, Decode
        w_enableBack        = 1'b1;   // Execute, MemoryAccess
        w_noOperation       = 1'b0;
        w_flushFetch        = 1'b0;
        w_flushDecode       = 1'b0;
        w_nextState         = RUN;
        w_nextResumeState   = RUN;
        w_nextBubbleCounter = r_bubbleCounter;

        if (w_freeze) begin
            // Whole pipeline holds; remember where to resume, counter untouched.
            w_enableFront     = 1'b0;
            w_enableBack      = 1'b0;
            w_nextState       = MEM_WAIT;
            w_nextResumeState = w_effectiveState;
        end else if (bus.enableBranchProgramCounter_Execute) begin
            // Taken branch discards both younger instructions, including any
            // load-use consumer, so no bubble is needed.
            w_flushFetch        = 1'b1;
            w_flushDecode       = 1'b1;
            w_nextBubbleCounter = '0;
        end else if (w_effectiveState == LOAD_WAIT) begin
            w_enableFront = 1'b0;
            w_noOperation = 1'b1;
            if (r_bubbleCounter <= BUBBLE_ONE) begin
                w_nextBubbleCounter = '0;
            end else begin
                w_nextState         = LOAD_WAIT;
                w_nextBubbleCounter = r_bubbleCounter - BUBBLE_ONE;
            end
        end else if (w_loadUse) begin
            w_enableFront = 1'b0;
            w_noOperation = 1'b1;
            if (MULTI_BUBBLE) begin
                w_nextState         = LOAD_WAIT;
                w_nextBubbleCounter = BUBBLE_INIT;
            end
        end else begin
            // Jump only flushes when its Decode slot is actually advancing.
            w_flushFetch = bus.enableJumpProgramCounter_Decode;
        end
    end

    always_ff @(posedge clock) begin
        if (resetMachine) begin
            r_state           <= RUN;
            r_resumeState     <= RUN;
            r_bubbleCounter   <= '0;
            r_stallCycleCount <= '0;
            r_flushCount      <= '0;
        end else begin
            r_state         <= w_nextState;
            r_resumeState   <= w_nextResumeState;
            r_bubbleCounter <= w_nextBubbleCounter;
            if (!w_enableFront) begin
                r_stallCycleCount <= f_saturatingIncrement(r_stallCycleCount);
            end
            if (w_flushFetch || w_flushDecode) begin
                r_flushCount <= f_saturatingIncrement(r_flushCount);
            end
        end
    end

    mips_forward_select #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_forwardA (
        .i_addressSource            (bus.addressReadA_Execute),
        .i_enableWrite_MemoryAccess (bus.enableWriteRegisterFile_MemoryAccess),
        .i_enableRead_MemoryAccess  (bus.enableReadDataMemory_MemoryAccess),
        .i_addressWrite_MemoryAccess(bus.addressWriteRegisterFile_MemoryAccess),
        .i_enableWrite_WriteBack    (bus.enableWriteRegisterFile_WriteBack),
        .i_addressWrite_WriteBack   (bus.addressWriteRegisterFile_WriteBack),
        .o_forwardSelect            (w_forwardA)
    );

    mips_forward_select #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_forwardB (
        .i_addressSource            (bus.addressReadB_Execute),
        .i_enableWrite_MemoryAccess (bus.enableWriteRegisterFile_MemoryAccess),
        .i_enableRead_MemoryAccess  (bus.enableReadDataMemory_MemoryAccess),
        .i_addressWrite_MemoryAccess(bus.addressWriteRegisterFile_MemoryAccess),
        .i_enableWrite_WriteBack    (bus.enableWriteRegisterFile_WriteBack),
        .i_addressWrite_WriteBack   (bus.addressWriteRegisterFile_WriteBack),
        .o_forwardSelect            (w_forwardB)
    );

    assign bus.enableProgramCounter_HazardUnit         = w_enableFront;
    assign bus.enableFetch_HazardUnit                  = w_enableFront;
    assign bus.enableDecode_HazardUnit                 = w_enableFront;
    assign bus.enableExecute_HazardUnit                = w_enableBack;
    assign bus.enableMemoryAccess_HazardUnit           = w_enableBack;
    assign bus.controlSignalSendNoOperation_HazardUnit = w_noOperation;
    assign bus.flushFetch_HazardUnit                   = w_flushFetch;
    assign bus.flushDecode_HazardUnit                  = w_flushDecode;
    assign bus.forwardA_HazardUnit                     = w_forwardA;
    assign bus.forwardB_HazardUnit                     = w_forwardB;
    assign bus.stallCycleCount                         = r_stallCycleCount;
    assign bus.flushCount                              = r_flushCount;

endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_mips_hazard_scoreboard
// Directed bench: u_dut (2 bubbles, 4-bit counters) takes all stimulus;
// u_dut3 (3 bubbles, 8-bit counters) mirrors the same inputs.
// ---------------------------------------------------------------------------
module tb_mips_hazard_scoreboard;

    logic clock = 1'b0;
    logic resetMachine;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    mips_hazard_scoreboard_if #(.REG_ADDR_WIDTH(5), .COUNT_WIDTH(4)) if1 ();
    mips_hazard_scoreboard_if #(.REG_ADDR_WIDTH(5), .COUNT_WIDTH(8)) if3 ();

    mips_hazard_scoreboard #(.REG_ADDR_WIDTH(5), .LOAD_USE_BUBBLES(2), .COUNT_WIDTH(4)) u_dut (
        .clock       (clock),
        .resetMachine(resetMachine),
        .bus         (if1)
    );

    mips_hazard_scoreboard #(.REG_ADDR_WIDTH(5), .LOAD_USE_BUBBLES(3), .COUNT_WIDTH(8)) u_dut3 (
        .clock       (clock),
        .resetMachine(resetMachine),
        .bus         (if3)
    );

    assign if3.addressReadA_Decode                   = if1.addressReadA_Decode;
    assign if3.addressReadB_Decode                   = if1.addressReadB_Decode;
    assign if3.useReadA_Decode                       = if1.useReadA_Decode;
    assign if3.useReadB_Decode                       = if1.useReadB_Decode;
    assign if3.enableJumpProgramCounter_Decode       = if1.enableJumpProgramCounter_Decode;
    assign if3.addressReadA_Execute                  = if1.addressReadA_Execute;
    assign if3.addressReadB_Execute                  = if1.addressReadB_Execute;
    assign if3.enableReadDataMemory_Execute          = if1.enableReadDataMemory_Execute;
    assign if3.addressWriteRegisterFile_Execute      = if1.addressWriteRegisterFile_Execute;
    assign if3.enableBranchProgramCounter_Execute    = if1.enableBranchProgramCounter_Execute;
    assign if3.enableWriteRegisterFile_MemoryAccess  = if1.enableWriteRegisterFile_MemoryAccess;
    assign if3.enableReadDataMemory_MemoryAccess     = if1.enableReadDataMemory_MemoryAccess;
    assign if3.addressWriteRegisterFile_MemoryAccess = if1.addressWriteRegisterFile_MemoryAccess;
    assign if3.dataMemoryRequest_MemoryAccess        = if1.dataMemoryRequest_MemoryAccess;
    assign if3.dataMemoryReady                       = if1.dataMemoryReady;
    assign if3.enableWriteRegisterFile_WriteBack     = if1.enableWriteRegisterFile_WriteBack;
    assign if3.addressWriteRegisterFile_WriteBack    = if1.addressWriteRegisterFile_WriteBack;

    // {PC, Fetch, Decode, Execute, MemoryAccess} and {NOP, flushFetch, flushDecode}
    logic [4:0] en1;
    logic [2:0] ctl1;
    assign en1  = {if1.enableProgramCounter_HazardUnit, if1.enableFetch_HazardUnit,
                   if1.enableDecode_HazardUnit, if1.enableExecute_HazardUnit,
                   if1.enableMemoryAccess_HazardUnit};
    assign ctl1 = {if1.controlSignalSendNoOperation_HazardUnit, if1.flushFetch_HazardUnit,
                   if1.flushDecode_HazardUnit};

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        if1.addressReadA_Decode                   = '0;
        if1.addressReadB_Decode                   = '0;
        if1.useReadA_Decode                       = 1'b0;
        if1.useReadB_Decode                       = 1'b0;
        if1.enableJumpProgramCounter_Decode       = 1'b0;
        if1.addressReadA_Execute                  = '0;
        if1.addressReadB_Execute                  = '0;
        if1.enableReadDataMemory_Execute          = 1'b0;
        if1.addressWriteRegisterFile_Execute      = '0;
        if1.enableBranchProgramCounter_Execute    = 1'b0;
        if1.enableWriteRegisterFile_MemoryAccess  = 1'b0;
        if1.enableReadDataMemory_MemoryAccess     = 1'b0;
        if1.addressWriteRegisterFile_MemoryAccess = '0;
        if1.dataMemoryRequest_MemoryAccess        = 1'b0;
        if1.dataMemoryReady                       = 1'b0;
        if1.enableWriteRegisterFile_WriteBack     = 1'b0;
        if1.addressWriteRegisterFile_WriteBack    = '0;
    endtask

    // Execute load to r8 while Decode reads r8 through source A.
    task automatic load_use_r8();
        if1.enableReadDataMemory_Execute     = 1'b1;
        if1.addressWriteRegisterFile_Execute = 5'd8;
        if1.addressReadA_Decode              = 5'd8;
        if1.useReadA_Decode                  = 1'b1;
    endtask

    task automatic do_reset();
        resetMachine = 1'b1;
        idle();
        tick();
        resetMachine = 1'b0;
    endtask

    initial begin
        resetMachine = 1'b1;
        idle();
        tick();
        tick();
        resetMachine = 1'b0;
        #1;
        check("reset_en",    en1, 5'b11111);
        check("reset_ctl",   ctl1, 3'b000);
        check("reset_fwdA",  if1.forwardA_HazardUnit, 2'b00);
        check("reset_fwdB",  if1.forwardB_HazardUnit, 2'b00);
        check("reset_stall", if1.stallCycleCount, 0);
        check("reset_flush", if1.flushCount, 0);

        // Load-use, 2 bubbles on u_dut and 3 on u_dut3
        load_use_r8();
        #1;
        check("lu_c1_en",  en1, 5'b00011);
        check("lu_c1_ctl", ctl1, 3'b100);
        tick();
        if1.enableReadDataMemory_Execute = 1'b0;
        #1;
        check("lu_c2_en",  en1, 5'b00011);
        check("lu_c2_ctl", ctl1, 3'b100);
        tick();
        check("lu_done_en",   en1, 5'b11111);
        check("lu_done_ctl",  ctl1, 3'b000);
        check("lu_stall",     if1.stallCycleCount, 2);
        check("lu3_c3_pc",    if3.enableProgramCounter_HazardUnit, 1'b0);
        check("lu3_c3_nop",   if3.controlSignalSendNoOperation_HazardUnit, 1'b1);
        tick();
        check("lu3_done_pc",  if3.enableProgramCounter_HazardUnit, 1'b1);
        check("lu3_stall",    if3.stallCycleCount, 3);
        check("lu_stall_hold", if1.stallCycleCount, 2);

        // Register 0 never stalls or forwards; unused source never stalls
        idle();
        if1.enableReadDataMemory_Execute = 1'b1;
        if1.useReadA_Decode              = 1'b1;
        #1;
        check("r0_nostall", en1, 5'b11111);
        if1.addressWriteRegisterFile_Execute = 5'd8;
        if1.addressReadB_Decode              = 5'd8;
        if1.useReadB_Decode                  = 1'b0;
        #1;
        check("unused_b_nostall", en1, 5'b11111);
        if1.useReadB_Decode = 1'b1;
        #1;
        check("b_stall", en1, 5'b00011);
        idle();
        if1.enableWriteRegisterFile_MemoryAccess = 1'b1;
        #1;
        check("r0_nofwd", if1.forwardA_HazardUnit, 2'b00);

        // Forwarding priority
        if1.addressWriteRegisterFile_MemoryAccess = 5'd5;
        if1.enableWriteRegisterFile_WriteBack     = 1'b1;
        if1.addressWriteRegisterFile_WriteBack    = 5'd5;
        if1.addressReadA_Execute                  = 5'd5;
        if1.addressReadB_Execute                  = 5'd5;
        #1;
        check("fwdA_mem", if1.forwardA_HazardUnit, 2'b01);
        check("fwdB_mem", if1.forwardB_HazardUnit, 2'b01);
        if1.enableReadDataMemory_MemoryAccess = 1'b1;
        #1;
        check("fwdA_wb_load", if1.forwardA_HazardUnit, 2'b10);
        if1.enableReadDataMemory_MemoryAccess = 1'b0;
        if1.addressReadB_Execute              = 5'd7;
        if1.addressWriteRegisterFile_WriteBack = 5'd7;
        #1;
        check("fwdA_mem_only", if1.forwardA_HazardUnit, 2'b01);
        check("fwdB_wb_only",  if1.forwardB_HazardUnit, 2'b10);
        if1.enableWriteRegisterFile_WriteBack = 1'b0;
        #1;
        check("fwdB_none", if1.forwardB_HazardUnit, 2'b00);

        // Freeze during LOAD_WAIT
        do_reset();
        load_use_r8();
        tick();
        if1.enableReadDataMemory_Execute   = 1'b0;
        if1.dataMemoryRequest_MemoryAccess = 1'b1;
        if1.dataMemoryReady                = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("frz_en",  en1, 5'b00000);
            check("frz_ctl", ctl1, 3'b000);
            tick();
        end
        if1.dataMemoryReady = 1'b1;
        #1;
        check("frz_rel_en",  en1, 5'b00011);
        check("frz_rel_ctl", ctl1, 3'b100);
        tick();
        idle();
        #1;
        check("frz_done_en", en1, 5'b11111);
        check("frz_stall",   if1.stallCycleCount, 5);

        // Branch versus load-use
        load_use_r8();
        if1.enableBranchProgramCounter_Execute = 1'b1;
        #1;
        check("br_lu_en",  en1, 5'b11111);
        check("br_lu_ctl", ctl1, 3'b011);
        tick();
        idle();
        #1;
        check("br_after_en", en1, 5'b11111);
        check("br_flush",    if1.flushCount, 1);
        load_use_r8();
        tick();
        idle();
        if1.enableBranchProgramCounter_Execute = 1'b1;
        #1;
        check("br_lw_en",  en1, 5'b11111);
        check("br_lw_ctl", ctl1, 3'b011);
        tick();
        idle();
        #1;
        check("br_lw_after_en", en1, 5'b11111);
        check("br_lw_flush",    if1.flushCount, 2);

        // Jump
        if1.enableJumpProgramCounter_Decode = 1'b1;
        load_use_r8();
        #1;
        check("jmp_stalled_ctl", ctl1, 3'b100);
        if1.enableReadDataMemory_Execute = 1'b0;
        #1;
        check("jmp_ctl", ctl1, 3'b010);
        check("jmp_en",  en1, 5'b11111);
        tick();
        if1.dataMemoryRequest_MemoryAccess = 1'b1;
        #1;
        check("jmp_frz_ctl", ctl1, 3'b000);
        idle();
        tick();
        check("jmp_flush", if1.flushCount, 3);
        check("jmp_stall", if1.stallCycleCount, 6);

        // Reset while in MEM_WAIT parked on LOAD_WAIT
        load_use_r8();
        tick();
        idle();
        if1.dataMemoryRequest_MemoryAccess = 1'b1;
        tick();
        #1;
        check("mw_en", en1, 5'b00000);
        do_reset();
        #1;
        check("mw_rst_en",    en1, 5'b11111);
        check("mw_rst_ctl",   ctl1, 3'b000);
        check("mw_rst_stall", if1.stallCycleCount, 0);
        check("mw_rst_flush", if1.flushCount, 0);

        // Counter saturation
        if1.dataMemoryRequest_MemoryAccess = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("sat_stall4",  if1.stallCycleCount, 15);
        check("sat_stall8",  if3.stallCycleCount, 20);
        idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_hazard_scoreboard.md
# mips_hazard_scoreboard

Parametrised hazard and forwarding controller for the five-stage MIPS pipeline. It combines three functions: load-use stall insertion with a configurable bubble count, full-pipeline freeze while data memory is not ready, and jump/branch flush control. It also produces the Execute-stage operand forwarding selects and keeps saturating performance counters. It sits beside the pipeline registers and drives every stage enable, flush and bubble control.

## Interface
- REG_ADDR_WIDTH, 5, register-file address width (RW below).
- LOAD_USE_BUBBLES, 1, bubbles inserted per load-use hazard; legal range 1..7.
- COUNT_WIDTH, 32, width of the performance counters.
- clock  in  1  pipeline clock; all state updates on the rising edge.
- resetMachine  in  1  synchronous, active-high reset.
- addressReadA_Decode / addressReadB_Decode  in  RW  Decode-stage source registers.
- useReadA_Decode / useReadB_Decode  in  1  the Decode instruction actually reads that source.
- addressReadA_Execute / addressReadB_Execute  in  RW  Execute-stage source registers.
- enableReadDataMemory_Execute  in  1  the Execute instruction is a load.
- addressWriteRegisterFile_Execute  in  RW  Execute destination register.
- enableWriteRegisterFile_MemoryAccess / enableReadDataMemory_MemoryAccess  in  1  MemoryAccess instruction writes a register / is a load.
- addressWriteRegisterFile_MemoryAccess  in  RW  MemoryAccess destination register.
- enableWriteRegisterFile_WriteBack  in  1 and addressWriteRegisterFile_WriteBack  in  RW  WriteBack producer.
- dataMemoryRequest_MemoryAccess  in  1  a load or store is requesting data memory this cycle.
- dataMemoryReady  in  1  data memory completes the request this cycle.
- enableJumpProgramCounter_Decode  in  1  jump resolved in Decode.
- enableBranchProgramCounter_Execute  in  1  taken branch resolved in Execute.
- enableProgramCounter_HazardUnit, enableFetch_HazardUnit, enableDecode_HazardUnit, enableExecute_HazardUnit, enableMemoryAccess_HazardUnit  out  1 each  stage-register enables.
- controlSignalSendNoOperation_HazardUnit  out  1  inject a NOP into the Decode→Execute register.
- flushFetch_HazardUnit / flushDecode_HazardUnit  out  1  clear the Fetch→Decode / Decode→Execute register.
- forwardA_HazardUnit / forwardB_HazardUnit  out  2  Execute operand select: 00 register file, 01 MemoryAccess result, 10 WriteBack result.
- stallCycleCount / flushCount  out  COUNT_WIDTH  saturating performance counters.

## Operation
- The block has three states. RUN is the normal state. LOAD_WAIT holds bubbleCounter of 3 bits. MEM_WAIT is the memory freeze.
- **Freeze condition:** dataMemoryRequest_MemoryAccess && !dataMemoryReady. This has the highest priority in every state.
  - All five enables are 0; no NOP, no flush.
  - The next state is MEM_WAIT. From LOAD_WAIT, the state and counter are held and resumed after the freeze.
  - When ready rises, the block returns to the prior state (RUN or LOAD_WAIT).
- **Load-use hazard (in RUN):** enableReadDataMemory_Execute=1 and the Execute destination is nonzero and equals a used Decode source (A with useReadA, or B with useReadB).
  - Response, same cycle: PC, Fetch and Decode enables are 0; NOP=1.
  - If LOAD_USE_BUBBLES>1, the state goes to LOAD_WAIT with bubbleCounter=LOAD_USE_BUBBLES-1.
- **LOAD_WAIT:** PC, Fetch and Decode are held and NOP=1 every cycle. bubbleCounter decrements each cycle; the block returns to RUN after the cycle in which the counter reads 1. The hazard is not re-detected while in LOAD_WAIT.
- **Taken branch (not frozen):** flushFetch=1 and flushDecode=1, and the PC is enabled. The branch overrides a same-cycle load-use stall and aborts LOAD_WAIT; the next state is RUN and NOP=0.
- **Jump:** flushFetch=1 only when Decode is not stalled and no freeze is active. A stalled jump stays in Decode and is re-evaluated the following cycle.
- **Forwarding, per operand:**
  - Select 01 when enableWriteRegisterFile_MemoryAccess=1, enableReadDataMemory_MemoryAccess=0, the MemoryAccess destination is nonzero and it equals the Execute source.
  - Otherwise select 10 when the WriteBack write is enabled, its destination is nonzero and it equals the source.
  - Otherwise select 00. MemoryAccess wins over WriteBack. Register 0 is never forwarded.
- **stallCycleCount:** +1 on every cycle that enableProgramCounter=0.
- **flushCount:** +1 on every cycle that either flush output is 1.
- Both counters saturate at all-ones.

## Timing
- **Reset** (synchronous, sampled on the clock edge), takes effect after that edge:
  - state RUN, bubbleCounter 0, both counters 0;
  - all enables 1, NOP 0, flushes 0, forwards 00.
- All stage controls and forwards are combinational from the inputs and the registered state: zero-cycle latency from hazard to response.
- A single load-use hazard costs exactly LOAD_USE_BUBBLES cycles with enableProgramCounter=0, excluding freeze cycles.
- The freeze releases in the same cycle that dataMemoryReady=1.
- Reset asserted in LOAD_WAIT or MEM_WAIT forces RUN on the next edge.

## Structure
- Shared package mips_pipeline_pkg holds:
  - the state enum (RUN, LOAD_WAIT, MEM_WAIT);
  - the forward-select enum (FWD_REGFILE=2'b00, FWD_MEMORY=2'b01, FWD_WRITEBACK=2'b10).
- One sub-module, mips_forward_select, instantiated twice (operands A and B). Its inputs are the source address and the two producers; its output is the 2-bit select.
- The counters and state machine stay in the top module.

## Test plan
- **Load-use:** LOAD_USE_BUBBLES=2, Execute load to r8, Decode reads r8 → 2 cycles with PC enable 0 and NOP 1, then RUN; stallCycleCount=2.
- **Register 0:** load to r0, Decode reads r0 → no stall. ALU writing r0 in MemoryAccess → forward 00.
- **Forwarding priority:** MemoryAccess and WriteBack both write r5, Execute A=r5 → forwardA=01. With the MemoryAccess instruction a load → forwardA=10.
- **Freeze during stall:** in LOAD_WAIT with counter 1, request=1 and ready=0 for 3 cycles → all enables 0 for 3 cycles, then 1 more bubble cycle; stallCycleCount=5 total.
- **Branch vs load-use:** branch taken in the same cycle as a load-use hazard → flushFetch=1, flushDecode=1, PC enable 1, NOP 0, state RUN, flushCount=1.
- **Reset and saturation:** reset in MEM_WAIT → RUN and outputs at reset values after one edge. With COUNT_WIDTH=4, 20 stall cycles → stallCycleCount holds 15.
